// File: rtl/reg_writeback_if.sv
// Producer handshakes and register-file write port of reg_writeback.
// The slave side is the writeback block; the master side is the pipeline and register file.
interface reg_writeback_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;
  logic              mem_valid;
  logic [ADDR_W-1:0] mem_rd;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;
  logic              regwrite;
  logic [ADDR_W-1:0] write_reg;
  logic [DATA_W-1:0] write_data;

  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    input  alu_ready, mem_ready, regwrite, write_reg, write_data
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    output alu_ready, mem_ready, regwrite, write_reg, write_data
  );
endinterface

// File: rtl/reg_writeback.sv
// Register-file writer: merges ALU and load results through a small FIFO into a single
// registered write port and tracks outstanding destinations for decode stalls.
module reg_writeback #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  reg_writeback_if.slave         wb,
  input  logic                   port_busy,
  input  logic                   claim_valid,
  input  logic [ADDR_W-1:0]      claim_rd,
  output logic [31:0]            pending,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] fifo_rd_q   [DEPTH];
  logic [ADDR_W-1:0] fifo_rd_d   [DEPTH];
  logic [DATA_W-1:0] fifo_data_q [DEPTH];
  logic [DATA_W-1:0] fifo_data_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [31:0]       pending_q, pending_d;
  logic              regwrite_q, regwrite_d;
  logic [ADDR_W-1:0] write_reg_q, write_reg_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;

  logic              full_s, mem_xfer_s, alu_xfer_s, push_s, pop_s;
  logic [ADDR_W-1:0] push_rd_s, head_rd_s;
  logic [DATA_W-1:0] push_data_s;
  logic [31:0]       set_mask_s, clr_mask_s;

  // Handshake decode; the load path wins because it holds the older instruction.
  always_comb begin
    full_s     = (count_q == FULL_CNT);
    mem_xfer_s = wb.mem_valid && !full_s;
    alu_xfer_s = wb.alu_valid && !full_s && !wb.mem_valid;
    if (mem_xfer_s) begin
      push_rd_s   = wb.mem_rd;
      push_data_s = wb.mem_data;
    end else begin
      push_rd_s   = wb.alu_rd;
      push_data_s = wb.alu_data;
    end
    push_s    = (mem_xfer_s || alu_xfer_s) && (push_rd_s != {ADDR_W{1'b0}});
    pop_s     = (count_q != {CNT_W{1'b0}}) && !port_busy;
    head_rd_s = fifo_rd_q[rd_ptr_q];
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      fifo_rd_d[i]   = (push_s && (wr_ptr_q == PTR_W'(i))) ? push_rd_s   : fifo_rd_q[i];
      fifo_data_d[i] = (push_s && (wr_ptr_q == PTR_W'(i))) ? push_data_s : fifo_data_q[i];
    end
    wr_ptr_d = push_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;

    if (pop_s) begin
      rd_ptr_d     = rd_ptr_q + PTR_W'(1);
      regwrite_d   = 1'b1;
      write_reg_d  = head_rd_s;
      write_data_d = fifo_data_q[rd_ptr_q];
    end else begin
      rd_ptr_d     = rd_ptr_q;
      regwrite_d   = 1'b0;
      write_reg_d  = write_reg_q;
      write_data_d = write_data_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Set is applied after clear so a same-edge claim from a younger instruction survives.
    clr_mask_s = pop_s ? (32'd1 << head_rd_s) : 32'd0;
    set_mask_s = (claim_valid && (claim_rd != {ADDR_W{1'b0}})) ? (32'd1 << claim_rd) : 32'd0;
    pending_d  = ((pending_q & ~clr_mask_s) | set_mask_s) & ~32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q     <= {PTR_W{1'b0}};
      rd_ptr_q     <= {PTR_W{1'b0}};
      count_q      <= {CNT_W{1'b0}};
      pending_q    <= 32'd0;
      regwrite_q   <= 1'b0;
      write_reg_q  <= {ADDR_W{1'b0}};
      write_data_q <= {DATA_W{1'b0}};
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      pending_q    <= pending_d;
      regwrite_q   <= regwrite_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
    end
  end

  // Storage needs no reset: count_q alone decides which entries are live.
  always_ff @(posedge clk) begin
    fifo_rd_q   <= fifo_rd_d;
    fifo_data_q <= fifo_data_d;
  end

  assign wb.mem_ready  = !full_s;
  assign wb.alu_ready  = !full_s && !wb.mem_valid;
  assign wb.regwrite   = regwrite_q;
  assign wb.write_reg  = write_reg_q;
  assign wb.write_data = write_data_q;
  assign pending       = pending_q;
  assign count         = count_q;
endmodule

// File: doc/reg_writeback.md
Name: reg_writeback

Overview:
- Writer side of the CPU register-file write port; the only block that drives regwrite, write_reg and write_data.
- Accepts writeback results from two producers: the single-cycle ALU path and the variable-latency load path.
- Serialises the results through a small FIFO so the register file sees at most one write per cycle.
- Keeps a pending-destination scoreboard that decode uses for stall decisions.

Parameters:
DEPTH, 4, FIFO entries; power of two, minimum 2
DATA_W, 32, writeback data width
ADDR_W, 5, register index width (32 registers)

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
alu_valid  input  1  ALU result offered
alu_rd  input  ADDR_W  ALU destination register
alu_data  input  DATA_W  ALU result
alu_ready  output  1  ALU result accepted this cycle
mem_valid  input  1  load result offered
mem_rd  input  ADDR_W  load destination register
mem_data  input  DATA_W  load data
mem_ready  output  1  load result accepted this cycle
port_busy  input  1  write port lent to the debug path; no pop this cycle
claim_valid  input  1  decode issues an instruction with a destination
claim_rd  input  ADDR_W  claimed destination
regwrite  output  1  register-file write enable (registered)
write_reg  output  ADDR_W  register-file write index (registered)
write_data  output  DATA_W  register-file write data (registered)
pending  output  32  scoreboard; bit i set means a write to xi is outstanding
count  output  clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset, synchronous, active-high. On the reset edge:
  - FIFO emptied; count=0.
  - pending=0.
  - regwrite=0, write_reg=0, write_data=0.
  - Entries in flight when reset arrives are discarded; no write pulse follows.
- Handshake:
  - mem_ready = !full.
  - alu_ready = !full && !mem_valid. The load path has fixed priority because it carries the older instruction.
  - A transfer happens when valid && ready are both high at the rising edge.
  - At most one push per cycle.
  - full means count==DEPTH at the start of the cycle. A same-cycle pop does not free a slot for that cycle's push.
  - Producers hold rd/data stable while valid is high and ready is low.
- rd==0: the transfer completes normally but nothing is enqueued, count does not change, and regwrite is never pulsed.
- Pop: at each edge where count>0 and !port_busy, the FIFO head is loaded into write_reg and write_data, and regwrite is set to 1 for the following cycle. Otherwise regwrite is 0 and write_reg/write_data hold their values.
- Latency: a result accepted at edge N with an empty FIFO and port free gives regwrite=1 in the cycle after edge N+1. The register file commits it at edge N+2.
- Simultaneous push and pop with count>0: count unchanged. FIFO order is strictly preserved.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Scoreboard:
  - At an edge with claim_valid and claim_rd!=0, pending[claim_rd] is set.
  - At a pop edge, pending[head rd] is cleared.
  - Claim and clear of the same rd at the same edge: set wins (the new claim belongs to a younger instruction).
  - pending[0] is always 0.
  - A second claim of an already-pending rd keeps the bit set. The bit clears on the first matching pop; ordering between multiple writes is decode's responsibility.
- All outputs are registered except alu_ready and mem_ready, which are combinational from count and mem_valid.

Test Plan:
- Reset, then alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF for one cycle -> alu_ready=1; regwrite=1 with write_reg=5, write_data=0xDEADBEEF exactly 2 cycles after the accept edge, for one cycle only; count returns to 0.
- alu_valid and mem_valid both high (alu_rd=3/0x11, mem_rd=4/0x22) -> mem accepted first, alu_ready=0 that cycle; ALU accepted next cycle; writes appear in order x4=0x22 then x3=0x11 on consecutive cycles.
- port_busy=1 while pushing 5 ALU results (rd 1..5) -> count reaches 4, alu_ready=0 and mem_ready=0 at full, 5th held off; release port_busy -> 5 writes in order rd1..rd5, 5th accepted only after the first pop.
- alu_rd=0, data 0x1234 -> alu_ready=1, count stays 0, regwrite never asserts.
- claim_rd=7, later ALU rd=7 retired -> pending[7]=1 until the pop edge, then 0; with a claim of rd=7 on that same pop edge, pending[7] stays 1; claim_rd=0 never sets pending[0].
- Fill FIFO with 3 entries and pending bits, assert reset for one cycle -> count=0, pending=0, regwrite=0, write_reg=0, write_data=0; no write pulse afterwards.
